// File: rtl/dmem_arbiter_if.sv
// Requester, memory and status signals of the data-memory arbiter.
// slave = arbiter side, master = requesters plus memory model side.
interface dmem_arbiter_if;
  logic        r0_req;
  logic        r0_we;
  logic        r0_byte;
  logic [15:0] r0_addr;
  logic [15:0] r0_wdata;
  logic        r0_gnt;
  logic        r0_valid;
  logic [15:0] r0_rdata;

  logic        r1_req;
  logic        r1_we;
  logic        r1_byte;
  logic [15:0] r1_addr;
  logic [15:0] r1_wdata;
  logic        r1_gnt;
  logic        r1_valid;
  logic [15:0] r1_rdata;

  logic        mem_we;
  logic        mem_re;
  logic        mem_sbyte;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic        busy;
  logic        err;

  modport slave (
    input  r0_req, r0_we, r0_byte, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_byte, r1_addr, r1_wdata,
    input  mem_rdata,
    output r0_gnt, r0_valid, r0_rdata,
    output r1_gnt, r1_valid, r1_rdata,
    output mem_we, mem_re, mem_sbyte, mem_addr, mem_wdata,
    output busy, err
  );

  modport master (
    output r0_req, r0_we, r0_byte, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_byte, r1_addr, r1_wdata,
    output mem_rdata,
    input  r0_gnt, r0_valid, r0_rdata,
    input  r1_gnt, r1_valid, r1_rdata,
    input  mem_we, mem_re, mem_sbyte, mem_addr, mem_wdata,
    input  busy, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 priority, port 1 starvation guard.
// Optional address range check enabled by defining DMEM_RANGE_CHK_EN.
//
// state  | meaning
// IDLE   | waiting for a request; arbitrate and latch the winner
// ACCESS | one memory cycle driven from the latch; gnt to winner
// RESP   | completion pulse (valid, err) to winner
module dmem_arbiter #(
  parameter int MEM_BYTES  = 43,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_CNT = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state_q, state_d;
  logic               win_q, win_d;
  logic               we_q, we_d;
  logic               byte_q, byte_d;
  logic [15:0]        addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic               oor_q, oor_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        rdata0_q, rdata0_d;
  logic [15:0]        rdata1_q, rdata1_d;

  logic               win1;
  logic               sel_we;
  logic               sel_byte;
  logic [15:0]        sel_addr;
  logic [15:0]        sel_wdata;
  logic               oor_raw;
  logic               oor_sel;
  logic [15:0]        rd_val;

  assign win1      = bus.r1_req && (!bus.r0_req || (cnt_q == STARVE_CNT));
  assign sel_we    = win1 ? bus.r1_we    : bus.r0_we;
  assign sel_byte  = win1 ? bus.r1_byte  : bus.r0_byte;
  assign sel_addr  = win1 ? bus.r1_addr  : bus.r0_addr;
  assign sel_wdata = win1 ? bus.r1_wdata : bus.r0_wdata;

  // a word touches addr and addr+1, so its last legal start is one lower
  assign oor_raw = sel_byte ? (sel_addr > 16'(MEM_BYTES - 1))
                            : (sel_addr > 16'(MEM_BYTES - 2));

`ifdef DMEM_RANGE_CHK_EN
  assign oor_sel = oor_raw;
`else
  logic unused_oor;
  assign unused_oor = oor_raw;
  assign oor_sel    = 1'b0;
`endif

  assign rd_val = oor_q  ? 16'h0000 :
                  byte_q ? {8'h00, bus.mem_rdata[7:0]} : bus.mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      oor_q    <= 1'b0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      byte_q   <= byte_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      oor_q    <= oor_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    we_d     = we_q;
    byte_d   = byte_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    oor_d    = oor_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      IDLE: begin
        if (!bus.r1_req) cnt_d = '0;
        if (bus.r0_req || bus.r1_req) begin
          state_d = ACCESS;
          win_d   = win1;
          we_d    = sel_we;
          byte_d  = sel_byte;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          oor_d   = oor_sel;
          if (win1)
            cnt_d = '0;
          else if (bus.r1_req && (cnt_q != STARVE_CNT))
            cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACCESS: begin
        state_d = RESP;
        // writes leave rdata alone unless the request was rejected
        if (!we_q || oor_q) begin
          if (win_q) rdata1_d = rd_val;
          else       rdata0_d = rd_val;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_we    = (state_q == ACCESS) &&  we_q && !oor_q;
  assign bus.mem_re    = (state_q == ACCESS) && !we_q && !oor_q;
  assign bus.mem_sbyte = byte_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.r0_gnt    = (state_q == ACCESS) && !win_q;
  assign bus.r1_gnt    = (state_q == ACCESS) &&  win_q;
  assign bus.r0_valid  = (state_q == RESP)   && !win_q;
  assign bus.r1_valid  = (state_q == RESP)   &&  win_q;
  assign bus.r0_rdata  = rdata0_q;
  assign bus.r1_rdata  = rdata1_q;
  assign bus.err       = (state_q == RESP)   &&  oor_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single byte-addressed, 16-bit-wide data memory between two requesters.
  - Port 0: pipeline MEM stage.
  - Port 1: loader/debug master.
- Fixed priority to port 0, with a starvation guard for port 1.
- Latches the winning request, drives the memory control/address/data for exactly one cycle, captures read data, then signals completion.
- Sits between the requesters and the data memory.

Parameters:
- MEM_BYTES, 43: number of valid byte locations, addresses 0..MEM_BYTES-1.
- STARVE_MAX, 4: consecutive lost arbitrations after which port 1 wins.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- r0_req  in  1  port 0 request; held with its fields until r0_gnt
- r0_we  in  1  port 0: 1 = write, 0 = read
- r0_byte  in  1  port 0: 1 = byte access, 0 = 16-bit word (little-endian, addr and addr+1)
- r0_addr  in  16  port 0 byte address
- r0_wdata  in  16  port 0 write data (byte access uses [7:0])
- r0_gnt  out  1  port 0 one-cycle grant pulse
- r0_valid  out  1  port 0 one-cycle completion pulse
- r0_rdata  out  16  port 0 read data, valid with r0_valid
- r1_req, r1_we, r1_byte, r1_addr, r1_wdata, r1_gnt, r1_valid, r1_rdata: same as the port 0 signals, for port 1
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_sbyte  out  1  memory byte-write select
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data ({mem[addr+1], mem[addr]}), combinational from mem_addr
- busy  out  1  high in every state except IDLE
- err  out  1  range error pulse, coincident with valid (see Optional Feature)

Behaviour:
- Reset: state IDLE; all outputs 0; starvation counter 0; latched request cleared.
  - Asynchronous reset mid-transaction aborts it.
  - No mem_we is issued after rst falls; the requester receives no valid.
- FSM, one transaction per 3 cycles:
  - IDLE: if any req is high, arbitrate; next state ACCESS. Otherwise stay in IDLE.
  - ACCESS: exactly one cycle.
    - mem_we = latched we; mem_re = ~latched we.
    - mem_addr, mem_wdata and mem_sbyte come from the latch.
    - Memory write commits at the closing edge.
    - mem_rdata is captured into the winner's rdata register at the closing edge.
    - Next state RESP.
  - RESP: winner's valid = 1 for one cycle; next state IDLE, unconditionally.
- Arbitration (IDLE, cycle N), grant registered:
  - Port 0 wins, unless r1_req = 1 and the counter equals STARVE_MAX; then port 1 wins.
  - The winner's gnt is high during cycle N+1 (ACCESS).
  - valid is high in N+2.
  - A req still high in N+3 (IDLE) is a new request.
- Starvation counter, width clog2(STARVE_MAX+1):
  - Increments at each arbitration where r1_req = 1 and port 0 wins.
  - Clears on a port 1 grant or whenever r1_req = 0 in IDLE.
  - Saturates at STARVE_MAX.
- Outside ACCESS: mem_we = mem_re = 0; mem_addr/mem_wdata/mem_sbyte hold their last values.
- Read data:
  - Word read: rdata = mem_rdata.
  - Byte read: rdata = {8'h00, mem_rdata[7:0]}.
  - The loser's rdata is unchanged.
- Write completion:
  - valid still pulses; rdata is unchanged.
- Simultaneous requests: both req high at arbitration; the loser gets no gnt and must keep req asserted.

Optional Feature:
- Macro: DMEM_RANGE_CHK_EN.
- Defined:
  - At arbitration, the winner's request is out of range if:
    - byte access with addr > MEM_BYTES-1, or
    - word access with addr > MEM_BYTES-2.
  - An out-of-range request is still granted and completes with the normal timing, but:
    - mem_we and mem_re stay 0 in ACCESS;
    - rdata is loaded with 16'h0000;
    - err pulses together with valid in RESP.
- Undefined: no check is made; every request is passed to memory; err is tied to 0.

Test Plan:
- Reset, then port 0 word write addr 4, data 16'h5678 -> r0_gnt in N+1 with mem_we=1, mem_addr=4, mem_sbyte=0; r0_valid in N+2; busy high N+1..N+2.
- Port 0 word read addr 4 after the memory holds 16'h5678 -> mem_re=1 for one cycle; r0_rdata=16'h5678 with r0_valid.
- Port 1 byte read addr 7, with memory bytes [7]=DE and [6]=AD -> r1_rdata=16'h00DE.
- Both ports request continuously, STARVE_MAX=4 -> grant order 0,0,0,0,1,0,0,0,0,1; counter returns to 0 after each port 1 grant.
- rst driven low during ACCESS of a port 0 write -> all outputs 0 immediately; no r0_valid; FSM resumes in IDLE after rst rises.
- With DMEM_RANGE_CHK_EN: port 0 word read addr 42 (MEM_BYTES=43) -> mem_re stays 0; r0_rdata=0; err=1 with r0_valid. Without the macro: mem_re=1 and err=0.
